// File: rtl/ab_pkg.sv
// Shared definitions for the 65C02 address-bus generator: ab_op field layout,
// selector codes and the canonical sequencer encodings.
package ab_pkg;

  // Bit positions inside the 12-bit ab_op word {I,P,H,F,AHB[2:0],ABL[3:0],CI}
  localparam int AB_CI_BIT  = 0;
  localparam int AB_ABL_LSB = 1;
  localparam int AB_ABL_MSB = 4;
  localparam int AB_AHB_LSB = 5;
  localparam int AB_AHB_MSB = 7;
  localparam int AB_F_BIT   = 8;
  localparam int AB_H_BIT   = 9;
  localparam int AB_P_BIT   = 10;
  localparam int AB_I_BIT   = 11;

  typedef struct packed {
    logic       i;
    logic       p;
    logic       h;
    logic       f;
    logic [2:0] ahb;
    logic [1:0] opb;   // ABL[3:2]
    logic [1:0] opa;   // ABL[1:0]
    logic       ci;
  } ab_op_t;

  // Low-adder operand selectors
  localparam logic [1:0] OPA_ZERO  = 2'b00;
  localparam logic [1:0] OPA_ZERO1 = 2'b01;
  localparam logic [1:0] OPA_ABL   = 2'b10;
  localparam logic [1:0] OPA_REG   = 2'b11;

  localparam logic [1:0] OPB_ZERO  = 2'b00;
  localparam logic [1:0] OPB_DB    = 2'b01;
  localparam logic [1:0] OPB_AHL   = 2'b10;
  localparam logic [1:0] OPB_PCL   = 2'b11;

  // High-byte selectors
  localparam logic [2:0] AHB_ZERO    = 3'b000;
  localparam logic [2:0] AHB_RSV1    = 3'b001;
  localparam logic [2:0] AHB_STACK   = 3'b010;
  localparam logic [2:0] AHB_RSV3    = 3'b011;
  localparam logic [2:0] AHB_ABH     = 3'b100;
  localparam logic [2:0] AHB_ABH_DEC = 3'b101;
  localparam logic [2:0] AHB_PCH     = 3'b110;
  localparam logic [2:0] AHB_DB      = 3'b111;

  // Canonical encodings; don't-care I/P bits are tied to 0
  localparam logic [11:0] AB_OP_INC          = 12'b0010_100_0010_1;
  localparam logic [11:0] AB_OP_ZP_DB_REG    = 12'b1110_000_0111_0;
  localparam logic [11:0] AB_OP_PC           = 12'b0000_110_1100_0;
  localparam logic [11:0] AB_OP_IDX_STORE_PC = 12'b1110_111_1011_0;
  localparam logic [11:0] AB_OP_SP           = 12'b0100_010_0011_0;
  localparam logic [11:0] AB_OP_IDX_KEEP_PC  = 12'b0010_111_1011_0;
  localparam logic [11:0] AB_OP_SP_INC       = 12'b0110_010_0011_1;
  localparam logic [11:0] AB_OP_SP_KEEP_PC   = 12'b0000_010_0011_0;
  localparam logic [11:0] AB_OP_SP_STORE_PC1 = 12'b1110_010_0011_0;
  localparam logic [11:0] AB_OP_FF_REG       = 12'b0001_000_0011_0;
  localparam logic [11:0] AB_OP_BR_FWD       = 12'b0010_100_0110_1;
  localparam logic [11:0] AB_OP_BR_BACK      = 12'b0010_101_0110_1;

endpackage

// File: rtl/ab_gen_hi_sel.sv
// Combinational high-byte mux/adder for the address bus. Carry from the low
// adder is folded in here; everything wraps mod 256.
module ab_hi_sel
  import ab_pkg::*;
(
  input  logic [2:0] ahb,
  input  logic       f,
  input  logic       cout,
  input  logic [7:0] ab_hi,
  input  logic [7:0] pc_hi,
  input  logic [7:0] db,
  output logic [7:0] hi
);

  logic [7:0] c8;
  assign c8 = {7'b0, cout};

  always_comb begin
    hi = 8'h00;
    case (ahb)
      AHB_ZERO:    hi = f ? 8'hFF : 8'h00;
      AHB_STACK:   hi = 8'h01;
      AHB_ABH:     hi = ab_hi + c8;
      AHB_ABH_DEC: hi = ab_hi + 8'hFF + c8;
      AHB_PCH:     hi = pc_hi + c8;
      AHB_DB:      hi = db + c8;
      default:     hi = 8'h00;   // reserved codes
    endcase
  end

endmodule

// File: rtl/ab_gen.sv
// Registered address-bus generator: low-byte adder, AB/PC/AHL registers and
// RDY stall. AB, PC and AHL all update from pre-edge values on the same edge.
module ab_gen
  import ab_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RDY,
  input  logic [11:0] ab_op,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
  output logic [15:0] AB,
  output logic [15:0] PC
);

  ab_op_t     op;
  logic [7:0] ahl;
  logic [7:0] opa, opb, hi;
  logic [8:0] lo_sum;

  assign op = ab_op_t'(ab_op);

  always_comb begin
    opa = 8'h00;
    case (op.opa)
      OPA_ABL: opa = AB[7:0];
      OPA_REG: opa = REG;
      default: opa = 8'h00;
    endcase
  end

  always_comb begin
    opb = 8'h00;
    case (op.opb)
      OPB_DB:  opb = DB;
      OPB_AHL: opb = ahl;
      OPB_PCL: opb = PC[7:0];
      default: opb = 8'h00;
    endcase
  end

  assign lo_sum = {1'b0, opa} + {1'b0, opb} + {8'b0, op.ci};

  ab_hi_sel u_hi_sel (
    .ahb   (op.ahb),
    .f     (op.f),
    .cout  (lo_sum[8]),
    .ab_hi (AB[15:8]),
    .pc_hi (PC[15:8]),
    .db    (DB),
    .hi    (hi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      AB  <= RESET_VEC;
      PC  <= 16'h0000;
      ahl <= 8'h00;
    end else if (RDY) begin
      AB <= {hi, lo_sum[7:0]};
      if (op.h) ahl <= DB;
      if (op.p) PC <= AB + {15'b0, op.i};
    end
  end

endmodule

// File: tb/tb_ab_gen.sv
// Directed bench for ab_gen: hand-computed expected AB/PC after each edge.
module tb_ab_gen;
  import ab_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RDY = 1'b1;
  logic [11:0] ab_op = '0;
  logic [7:0]  DB = '0;
  logic [7:0]  REG = '0;
  logic [15:0] AB, PC;

  int n_chk = 0;
  int n_fail = 0;

  ab_gen #(.RESET_VEC(16'hFFFC)) dut (
    .clk   (clk),
    .reset (reset),
    .RDY   (RDY),
    .ab_op (ab_op),
    .DB    (DB),
    .REG   (REG),
    .AB    (AB),
    .PC    (PC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic [11:0] op, input logic [7:0] db, input logic [7:0] rg,
                      input logic rdy, input logic rst);
    ab_op = op; DB = db; REG = rg; RDY = rdy; reset = rst;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [11:0] op, input logic [7:0] db, input logic [7:0] rg);
    step(op, db, rg, 1'b1, 1'b0);
  endtask

  // Two keep-PC indexed cycles with REG=0: AHL<=lo, then AB<={hi,lo}
  task automatic load_ab(input logic [7:0] hi, input logic [7:0] lo);
    run(AB_OP_IDX_KEEP_PC, lo, 8'h00);
    run(AB_OP_IDX_KEEP_PC, hi, 8'h00);
  endtask

  initial begin
    #2;
    step(12'h000, 8'h00, 8'h00, 1'b1, 1'b1);
    check("reset_ab", AB, 16'hFFFC);
    check("reset_pc", PC, 16'h0000);

    for (int k = 0; k < 3; k++) begin
      step(12'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      check("hold_ab", AB, 16'hFFFC);
      check("hold_pc", PC, 16'h0000);
    end
    run(AB_OP_IDX_KEEP_PC, 8'h00, 8'h00);
    check("hold_ahl", AB, 16'h0000);

    load_ab(8'h12, 8'hFF);
    check("load_ab", AB, 16'h12FF);
    run(AB_OP_INC, 8'h00, 8'h00);
    check("inc_page", AB, 16'h1300);
    load_ab(8'hFF, 8'hFF);
    run(AB_OP_INC, 8'h00, 8'h00);
    check("inc_wrap", AB, 16'h0000);

    load_ab(8'h20, 8'hF0);
    run(AB_OP_BR_FWD, 8'h20, 8'h00);
    check("br_fwd", AB, 16'h2111);
    load_ab(8'h20, 8'h05);
    run(AB_OP_BR_BACK, 8'hF0, 8'h00);
    check("br_back", AB, 16'h1FF6);

    load_ab(8'h04, 8'h11);
    run(AB_OP_INC, 8'h80, 8'h00);
    check("idx_inc", AB, 16'h0412);
    run(AB_OP_IDX_KEEP_PC, 8'h12, 8'h90);
    check("idx_keep_ab", AB, 16'h1310);
    check("idx_keep_pc", PC, 16'h0000);

    load_ab(8'h02, 8'hFF);
    run(AB_OP_INC, 8'h80, 8'h00);
    check("idx2_inc", AB, 16'h0300);
    run(AB_OP_IDX_STORE_PC, 8'h12, 8'h90);
    check("idx_store_ab", AB, 16'h1310);
    check("idx_store_pc", PC, 16'h0301);

    run(AB_OP_SP, 8'h00, 8'hFD);
    check("sp_ab", AB, 16'h01FD);
    check("sp_pc", PC, 16'h1310);
    run(AB_OP_SP_INC, 8'h00, 8'hFD);
    check("sp_inc", AB, 16'h01FE);
    run(AB_OP_FF_REG, 8'h00, 8'h10);
    check("ff_reg", AB, 16'hFF10);
    run(AB_OP_SP_INC, 8'h00, 8'hFF);
    check("sp_inc_wrap", AB, 16'h0100);

    run(AB_OP_ZP_DB_REG, 8'h12, 8'h34);
    check("zp_db_reg_ab", AB, 16'h0046);
    check("zp_db_reg_pc", PC, 16'h0101);
    run(12'b0000_001_0011_0, 8'hAA, 8'h55);
    check("rsv1", AB, 16'h0055);
    run(12'b0000_011_0011_0, 8'hAA, 8'h66);
    check("rsv3", AB, 16'h0066);

    load_ab(8'h45, 8'h67);
    run(AB_OP_SP, 8'h00, 8'h00);
    check("pc_load", PC, 16'h4567);
    run(AB_OP_PC, 8'h00, 8'h00);
    check("ret_pc_ab", AB, 16'h4567);
    check("ret_pc_pc", PC, 16'h4567);
    run(AB_OP_SP_KEEP_PC, 8'h00, 8'h33);
    check("sp_keep_ab", AB, 16'h0133);
    check("sp_keep_pc", PC, 16'h4567);
    run(AB_OP_SP_STORE_PC1, 8'h00, 8'h33);
    check("sp_store_pc", PC, 16'h0134);

    load_ab(8'h05, 8'h00);
    run(AB_OP_INC, 8'h77, 8'h00);
    check("mid_inc", AB, 16'h0501);
    step(AB_OP_IDX_KEEP_PC, 8'h12, 8'h90, 1'b1, 1'b1);
    check("mid_reset_ab", AB, 16'hFFFC);
    check("mid_reset_pc", PC, 16'h0000);
    run(AB_OP_IDX_KEEP_PC, 8'h00, 8'h00);
    check("mid_reset_ahl", AB, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
